// File: rtl/controle_presenca_pkg.sv
// Shared definitions for the presence controller: FSM state codes,
// BCD digit limit, default distance thresholds and a BCD validity helper.
package controle_presenca_pkg;

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    ESPERA  = 4'd1,
    MEDE    = 4'd2,
    AGUARDA = 4'd3,
    AVALIA  = 4'd4,
    FALHA   = 4'd5
  } estado_t;

  localparam logic [3:0]  DIGITO_MAX        = 4'd9;
  localparam logic [11:0] LIMIAR_ON_PADRAO  = 12'h020;
  localparam logic [11:0] LIMIAR_OFF_PADRAO = 12'h030;

  // A reading is usable only if each of its three packed-BCD digits is 0..9.
  function automatic logic bcd_valido(input logic [11:0] valor);
    return (valor[11:8] <= DIGITO_MAX) &&
           (valor[7:4]  <= DIGITO_MAX) &&
           (valor[3:0]  <= DIGITO_MAX);
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear (zera has priority over conta)
// and a terminal-count flag that is high while the count equals M-1.
module contador_m #(
  parameter int M = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0] ULTIMO = W'(M - 1);

  logic [W-1:0] valor;

  // Count register: clear on reset or zera, otherwise wrap at M-1 while enabled.
  always_ff @(posedge clock) begin
    if (reset || zera) begin
      valor <= '0;
    end else if (conta) begin
      valor <= (valor == ULTIMO) ? '0 : valor + 1'b1;
    end
  end

  assign fim = (valor == ULTIMO);

endmodule

// File: rtl/controle_presenca.sv
// Measurement scheduler and presence detector. Issues periodic medir pulses,
// supervises each request with a watchdog, registers valid BCD distances and
// derives a debounced, hysteretic presence flag from consecutive readings.
module controle_presenca
  import controle_presenca_pkg::*;
#(
  parameter int          PERIODO    = 5_000_000,
  parameter int          TIMEOUT    = 2_500_000,
  parameter int          N_CONSEC   = 3,
  parameter logic [11:0] LIMIAR_ON  = LIMIAR_ON_PADRAO,
  parameter logic [11:0] LIMIAR_OFF = LIMIAR_OFF_PADRAO,
  parameter int          FALHAS_MAX = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        habilita,
  input  logic        pronto_sensor,
  input  logic [11:0] medida,
  output logic        medir,
  output logic [11:0] ultima_medida,
  output logic        nova_medida,
  output logic        presenca,
  output logic        erro_sensor,
  output logic [3:0]  db_estado
);

  localparam int CW = $clog2(N_CONSEC + 1);
  localparam int FW = $clog2(FALHAS_MAX + 1);
  localparam logic [CW-1:0] N_MAX = CW'(N_CONSEC);
  localparam logic [FW-1:0] F_MAX = FW'(FALHAS_MAX);

  estado_t estado, estado_prox;

  logic          zera_periodo, conta_periodo, fim_periodo;
  logic          zera_timeout, conta_timeout, fim_timeout;
  logic          pronto_valido;
  logic [CW-1:0] cont_perto, cont_longe, perto_prox, longe_prox;
  logic [FW-1:0] falhas, falhas_prox;

  // The period counter is zeroed on the edge that enters MEDE, so its value
  // equals the number of cycles since the last medir and pulses land exactly
  // PERIODO cycles apart; the watchdog uses the same origin.
  contador_m #(.M(PERIODO)) u_periodo (
    .clock (clock),
    .reset (reset),
    .zera  (zera_periodo),
    .conta (conta_periodo),
    .fim   (fim_periodo)
  );

  contador_m #(.M(TIMEOUT)) u_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (zera_timeout),
    .conta (conta_timeout),
    .fim   (fim_timeout)
  );

  assign pronto_valido = pronto_sensor && bcd_valido(medida);
  assign perto_prox    = (cont_perto == N_MAX) ? cont_perto : cont_perto + 1'b1;
  assign longe_prox    = (cont_longe == N_MAX) ? cont_longe : cont_longe + 1'b1;
  assign falhas_prox   = (falhas == F_MAX) ? falhas : falhas + 1'b1;

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INICIAL;
    end else begin
      estado <= estado_prox;
    end
  end

  // Next-state logic and counter controls; counters restart whenever MEDE is next.
  always_comb begin
    estado_prox   = estado;
    zera_periodo  = 1'b0;
    conta_periodo = 1'b0;
    zera_timeout  = 1'b0;
    conta_timeout = 1'b0;
    case (estado)
      INICIAL: begin
        zera_periodo = 1'b1;
        zera_timeout = 1'b1;
        if (habilita) estado_prox = MEDE;
      end
      ESPERA: begin
        conta_periodo = 1'b1;
        if (!habilita)        estado_prox = INICIAL;
        else if (fim_periodo) estado_prox = MEDE;
      end
      MEDE: begin
        conta_periodo = 1'b1;
        conta_timeout = 1'b1;
        estado_prox   = AGUARDA;
      end
      AGUARDA: begin
        conta_periodo = 1'b1;
        conta_timeout = 1'b1;
        if (pronto_sensor)    estado_prox = pronto_valido ? AVALIA : FALHA;
        else if (fim_timeout) estado_prox = FALHA;
      end
      AVALIA, FALHA: begin
        conta_periodo = 1'b1;
        estado_prox   = ESPERA;
      end
      default: begin
        estado_prox  = INICIAL;
        zera_periodo = 1'b1;
        zera_timeout = 1'b1;
      end
    endcase
    if (estado_prox == MEDE) begin
      zera_periodo = 1'b1;
      zera_timeout = 1'b1;
    end
  end

  // Datapath: capture on accepted pronto, then update debounce/failure state
  // on the edge that leaves AVALIA or FALHA.
  always_ff @(posedge clock) begin
    if (reset) begin
      ultima_medida <= 12'h000;
      presenca      <= 1'b0;
      erro_sensor   <= 1'b0;
      cont_perto    <= '0;
      cont_longe    <= '0;
      falhas        <= '0;
    end else begin
      case (estado)
        INICIAL: begin
          cont_perto <= '0;
          cont_longe <= '0;
          falhas     <= '0;
        end
        AGUARDA: begin
          if (pronto_valido) ultima_medida <= medida;
        end
        AVALIA: begin
          falhas      <= '0;
          erro_sensor <= 1'b0;
          if (ultima_medida < LIMIAR_ON) begin
            cont_perto <= perto_prox;
            cont_longe <= '0;
            if (perto_prox == N_MAX) presenca <= 1'b1;
          end else if (ultima_medida > LIMIAR_OFF) begin
            cont_longe <= longe_prox;
            cont_perto <= '0;
            if (longe_prox == N_MAX) presenca <= 1'b0;
          end else begin
            cont_perto <= '0;
            cont_longe <= '0;
          end
        end
        FALHA: begin
          falhas <= falhas_prox;
          if (falhas_prox == F_MAX) erro_sensor <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign medir       = (estado == MEDE);
  assign nova_medida = (estado == AVALIA);
  assign db_estado   = estado;

endmodule

// File: tb/tb_controle_presenca.sv
// Self-checking bench for controle_presenca: an event-level reference model
// predicts every output each cycle, and directed scenarios add literal checks.
module tb_controle_presenca;

  localparam int          PERIODO    = 100;
  localparam int          TIMEOUT    = 40;
  localparam int          N_CONSEC   = 3;
  localparam logic [11:0] LIMIAR_ON  = 12'h020;
  localparam logic [11:0] LIMIAR_OFF = 12'h030;
  localparam int          FALHAS_MAX = 2;

  logic        clock;
  logic        reset;
  logic        habilita;
  logic        pronto_sensor;
  logic [11:0] medida;
  logic        medir;
  logic [11:0] ultima_medida;
  logic        nova_medida;
  logic        presenca;
  logic        erro_sensor;
  logic [3:0]  db_estado;

  int n_assert = 0;
  int n_fail   = 0;
  int ciclo    = 0;
  bit ativo    = 0;
  int ultimo_medir = 0;
  bit checa_periodo = 0;

  // reference model state
  bit          m_idle = 1;
  bit          m_waiting = 0;
  int          m_t_medir = 0;
  int          m_res = 0;
  bit          m_pend_eval = 0;
  bit          m_pend_fail = 0;
  logic [11:0] m_leitura = '0;
  int          m_falhas = 0;
  int          fila[$];
  logic        exp_medir = 0;
  logic        exp_nova = 0;
  logic [11:0] exp_ultima = '0;
  logic        exp_pres = 0;
  logic        exp_erro = 0;

  controle_presenca #(
    .PERIODO    (PERIODO),
    .TIMEOUT    (TIMEOUT),
    .N_CONSEC   (N_CONSEC),
    .LIMIAR_ON  (LIMIAR_ON),
    .LIMIAR_OFF (LIMIAR_OFF),
    .FALHAS_MAX (FALHAS_MAX)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .habilita      (habilita),
    .pronto_sensor (pronto_sensor),
    .medida        (medida),
    .medir         (medir),
    .ultima_medida (ultima_medida),
    .nova_medida   (nova_medida),
    .presenca      (presenca),
    .erro_sensor   (erro_sensor),
    .db_estado     (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string nome, input logic [31:0] atual,
                              input logic [31:0] esperado);
    n_assert++;
    if (atual !== esperado) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nome, atual, esperado, ciclo);
    end
  endtask

  function automatic bit bcd_ok(input logic [11:0] v);
    return (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Presence follows the last N_CONSEC valid readings: all near -> 1, all far -> 0.
  task automatic aplica_leitura(input logic [11:0] v);
    int cls;
    bit todos_perto, todos_longe;
    exp_erro = 1'b0;
    m_falhas = 0;
    if (v < LIMIAR_ON)       cls = 1;
    else if (v > LIMIAR_OFF) cls = 2;
    else                     cls = 0;
    fila.push_back(cls);
    if (fila.size() > N_CONSEC) void'(fila.pop_front());
    if (fila.size() == N_CONSEC) begin
      todos_perto = 1;
      todos_longe = 1;
      foreach (fila[i]) begin
        if (fila[i] != 1) todos_perto = 0;
        if (fila[i] != 2) todos_longe = 0;
      end
      if (todos_perto) exp_pres = 1'b1;
      if (todos_longe) exp_pres = 1'b0;
    end
  endtask

  // Reference model: predicts outputs for the interval following each edge.
  always @(posedge clock) begin
    ciclo++;
    exp_medir = 1'b0;
    exp_nova  = 1'b0;
    if (reset) begin
      m_idle = 1; m_waiting = 0; m_pend_eval = 0; m_pend_fail = 0;
      m_falhas = 0; fila.delete();
      exp_ultima = '0; exp_pres = 0; exp_erro = 0;
    end else begin
      if (m_pend_eval) begin
        m_pend_eval = 0;
        aplica_leitura(m_leitura);
      end
      if (m_pend_fail) begin
        m_pend_fail = 0;
        m_falhas++;
        if (m_falhas >= FALHAS_MAX) exp_erro = 1'b1;
      end
      if (m_idle) begin
        if (habilita) begin
          exp_medir = 1; m_t_medir = ciclo; m_waiting = 1; m_idle = 0;
        end
      end else if (m_waiting) begin
        if (pronto_sensor && ciclo >= m_t_medir + 2) begin
          m_waiting = 0; m_res = ciclo;
          if (bcd_ok(medida)) begin
            exp_nova = 1; exp_ultima = medida; m_leitura = medida; m_pend_eval = 1;
          end else begin
            m_pend_fail = 1;
          end
        end else if (ciclo == m_t_medir + TIMEOUT) begin
          m_waiting = 0; m_res = ciclo; m_pend_fail = 1;
        end
      end else if (ciclo >= m_res + 2) begin
        if (!habilita) begin
          m_idle = 1; fila.delete(); m_falhas = 0;
        end else if (ciclo == m_t_medir + PERIODO) begin
          exp_medir = 1; m_t_medir = ciclo; m_waiting = 1;
        end
      end
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clock) begin
    if (ativo) begin
      check_output("medir",         medir,         exp_medir);
      check_output("nova_medida",   nova_medida,   exp_nova);
      check_output("ultima_medida", ultima_medida, exp_ultima);
      check_output("presenca",      presenca,      exp_pres);
      check_output("erro_sensor",   erro_sensor,   exp_erro);
    end
  end

  task automatic espera_medir(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      if (medir) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_assert++;
      n_fail++;
      $display("[TB] FAIL wait_medir: no medir within 200 cycles (cycle %0d)", ciclo);
    end else begin
      if (checa_periodo) check_output("periodo_medir", ciclo - ultimo_medir, PERIODO);
      ultimo_medir  = ciclo;
      checa_periodo = 1;
    end
  endtask

  // Answer the next request after 'atraso' cycles; report state/nova right after the pulse.
  task automatic apply_stimulus(input logic [11:0] valor, input int atraso,
                                output logic [3:0] estado_pos, output logic nova_pos);
    bit ok;
    estado_pos = '0;
    nova_pos   = 1'b0;
    espera_medir(ok);
    if (ok) begin
      repeat (atraso) begin @(posedge clock); #1; end
      pronto_sensor = 1'b1;
      medida        = valor;
      @(posedge clock); #1;
      pronto_sensor = 1'b0;
      estado_pos    = db_estado;
      nova_pos      = nova_medida;
      @(posedge clock); #1;
    end
  endtask

  // Let the next request time out; report the state when the watchdog fires.
  task automatic sem_resposta(output logic [3:0] estado_pos);
    bit ok;
    estado_pos = '0;
    espera_medir(ok);
    if (ok) begin
      repeat (TIMEOUT) begin @(posedge clock); #1; end
      estado_pos = db_estado;
      @(posedge clock); #1;
    end
  endtask

  initial begin
    logic [3:0] est;
    logic       nv;
    bit         ok;
    reset = 1'b1; habilita = 1'b0; pronto_sensor = 1'b0; medida = '0;
    repeat (3) begin @(posedge clock); #1; end
    ativo = 1;
    check_output("rst_medir", medir, 0);
    check_output("rst_nova", nova_medida, 0);
    check_output("rst_presenca", presenca, 0);
    check_output("rst_erro", erro_sensor, 0);
    check_output("rst_ultima", ultima_medida, 12'h000);
    check_output("rst_estado", db_estado, 0);

    reset = 1'b0;
    habilita = 1'b1;

    // three near readings: presence only after the third
    apply_stimulus(12'h015, 10, est, nv);
    check_output("nova_after_pronto", nv, 1);
    apply_stimulus(12'h015, 10, est, nv);
    check_output("presenca_after_2nd", presenca, 0);
    apply_stimulus(12'h015, 10, est, nv);
    check_output("presenca_after_3rd", presenca, 1);
    check_output("ultima_015", ultima_medida, 12'h015);

    // band readings hold presence, three far readings drop it
    apply_stimulus(12'h025, 10, est, nv);
    apply_stimulus(12'h025, 10, est, nv);
    check_output("presenca_band", presenca, 1);
    apply_stimulus(12'h045, 10, est, nv);
    apply_stimulus(12'h045, 10, est, nv);
    check_output("presenca_2nd_far", presenca, 1);
    apply_stimulus(12'h045, 10, est, nv);
    check_output("presenca_3rd_far", presenca, 0);

    // a band reading breaks the near streak
    apply_stimulus(12'h010, 10, est, nv);
    apply_stimulus(12'h010, 10, est, nv);
    apply_stimulus(12'h025, 10, est, nv);
    apply_stimulus(12'h010, 10, est, nv);
    check_output("presenca_broken_streak", presenca, 0);

    // two timeouts raise the error flag, a valid reading clears it
    sem_resposta(est);
    check_output("estado_timeout1", est, 5);
    check_output("erro_after_1st_fail", erro_sensor, 0);
    sem_resposta(est);
    check_output("estado_timeout2", est, 5);
    check_output("erro_after_2nd_fail", erro_sensor, 1);
    check_output("ultima_kept", ultima_medida, 12'h010);
    apply_stimulus(12'h015, 10, est, nv);
    check_output("erro_cleared", erro_sensor, 0);

    // invalid BCD fails; pronto together with timeout is accepted
    apply_stimulus(12'h0A5, 10, est, nv);
    check_output("estado_bad_bcd", est, 5);
    check_output("nova_bad_bcd", nv, 0);
    apply_stimulus(12'h050, TIMEOUT - 1, est, nv);
    check_output("estado_pronto_vs_timeout", est, 4);
    check_output("nova_pronto_vs_timeout", nv, 1);
    check_output("ultima_050", ultima_medida, 12'h050);

    // reset in the middle of a request, then a late pronto
    espera_medir(ok);
    repeat (5) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    check_output("midrst_ultima", ultima_medida, 12'h000);
    check_output("midrst_presenca", presenca, 0);
    check_output("midrst_erro", erro_sensor, 0);
    check_output("midrst_estado", db_estado, 0);
    reset = 1'b0;
    pronto_sensor = 1'b1;
    medida = 12'h015;
    @(posedge clock); #1;
    pronto_sensor = 1'b0;
    check_output("late_pronto_nova", nova_medida, 0);
    check_output("late_pronto_ultima", ultima_medida, 12'h000);

    habilita = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    @(negedge clock); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
